// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the RV32I instruction-fetch front end.
package fetch_stage_pkg;

  localparam int unsigned XLEN_DEFAULT     = 32;
  localparam int unsigned ILEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between fetch (master) and imem (slave).
interface fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush; flush wins over push/pop.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  fetch_entry_t               data_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output fetch_entry_t               head_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC/issue control, in-order response tracking with redirect discard,
// and an instruction FIFO presenting {pc, instr} to decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned    XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int unsigned    DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_stage_if.master   imem,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [6:0]      id_op_code,
  output logic [2:0]      id_func3,
  output logic [6:0]      id_func7
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  // Doomed requests can stack past DEPTH across back-to-back redirects with a slow memory.
  localparam int unsigned OW = CW + 2;
  localparam int unsigned SW = OW + 1;

  logic            started_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   discard_q, discard_d;

  logic            req_fire, rsp_fire;
  logic [SW-1:0]   occupancy;
  logic            fifo_push, fifo_push_req, fifo_pop, fifo_flush;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  fetch_entry_t    fifo_din, fifo_head;

  // Live requests plus buffered instructions must never exceed the FIFO depth.
  assign occupancy = SW'(outstanding_q - discard_q) + SW'(fifo_count);

  assign imem.imem_req_valid = started_q && !redirect_valid && (occupancy < SW'(DEPTH));
  assign imem.imem_req_addr  = pc_q;

  assign req_fire = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_fire = imem.imem_rsp_valid;

  assign fifo_din = '{pc: 32'(rsp_pc_q), instr: imem.imem_rsp_data};

  always_comb begin
    pc_d          = pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + OW'(req_fire) - OW'(rsp_fire);
    fifo_push_req = 1'b0;
    fifo_flush    = 1'b0;
    fifo_pop      = id_valid && id_ready && !redirect_valid;
    if (redirect_valid) begin
      pc_d       = redirect_pc & ~XLEN'(3);
      rsp_pc_d   = redirect_pc & ~XLEN'(3);
      discard_d  = outstanding_q - OW'(rsp_fire);
      fifo_flush = 1'b1;
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_fire) begin
        if (discard_q != '0) begin
          discard_d = discard_q - OW'(1);
        end else begin
          fifo_push_req = 1'b1;
          rsp_pc_d      = rsp_pc_q + XLEN'(4);
        end
      end
    end
  end

  assign fifo_push = fifo_push_req && (!fifo_full || fifo_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q     <= 1'b0;
      pc_q          <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      started_q     <= 1'b1;
      pc_q          <= pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_i  (fifo_din),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_push_req && fifo_full && !fifo_pop));

  assign id_valid   = !fifo_empty;
  assign id_instr   = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign id_pc      = fifo_empty ? rsp_pc_q : XLEN'(fifo_head.pc);
  assign id_op_code = id_instr[6:0];
  assign id_func3   = id_instr[14:12];
  assign id_func7   = id_instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: in-bench memory, queue-based reference model, directed scenarios.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int unsigned DEPTH = 2;

  typedef struct { logic [31:0] addr; int due; }       mreq_t;
  typedef struct { logic [31:0] addr; bit doomed; }    infl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [6:0]  id_op_code;
  logic [2:0]  id_func3;
  logic [6:0]  id_func7;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  mreq_t        memq[$];
  infl_t        infl[$];
  fetch_entry_t efifo[$];
  logic [31:0]  m_pc;
  bit           m_started;

  fetch_stage_if #(.XLEN(32)) imem ();

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_op_code     (id_op_code),
    .id_func3       (id_func3),
    .id_func7       (id_func7)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory: one in-order response per cycle, data = addr + 0x13.
  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    if (rst_n && memq.size() != 0 && memq[0].due <= cyc) begin
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = memq[0].addr + 32'h13;
      void'(memq.pop_front());
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic tick();
    step();
    #1;
  endtask

  // Reference model and per-cycle compare.
  always @(negedge clk) begin
    int          live;
    bit          exp_rv, exp_idv;
    logic [31:0] exp_instr;
    infl_t       e;
    if (!rst_n) begin
      chk("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_id_instr", id_instr, NOP_INSTR);
      chk("rst_id_pc", id_pc, 32'h0);
      m_started = 1'b0;
      m_pc      = 32'h0;
      infl.delete();
      efifo.delete();
      memq.delete();
    end else begin
      live = 0;
      foreach (infl[i]) if (!infl[i].doomed) live++;
      exp_rv    = m_started && !redirect_valid && (live + efifo.size() < DEPTH);
      exp_idv   = efifo.size() != 0;
      exp_instr = exp_idv ? efifo[0].instr : NOP_INSTR;

      chk("req_valid", 32'(imem.imem_req_valid), 32'(exp_rv));
      if (exp_rv) chk("req_addr", imem.imem_req_addr, m_pc);
      chk("id_valid", 32'(id_valid), 32'(exp_idv));
      chk("id_instr", id_instr, exp_instr);
      if (exp_idv) chk("id_pc", id_pc, efifo[0].pc);
      chk("id_op_code", 32'(id_op_code), 32'(exp_instr[6:0]));
      chk("id_func3", 32'(id_func3), 32'(exp_instr[14:12]));
      chk("id_func7", 32'(id_func7), 32'(exp_instr[31:25]));

      if (imem.imem_req_valid && imem.imem_req_ready)
        memq.push_back('{addr: imem.imem_req_addr, due: cyc + lat});

      if (imem.imem_rsp_valid && infl.size() == 0) begin
        errors++;
        $display("FAIL rsp_untracked: response with no request issued by model at t=%0t", $time);
      end

      if (redirect_valid) begin
        if (imem.imem_rsp_valid && infl.size() != 0) void'(infl.pop_front());
        foreach (infl[i]) infl[i].doomed = 1'b1;
        efifo.delete();
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (exp_idv && id_ready) void'(efifo.pop_front());
        if (imem.imem_rsp_valid && infl.size() != 0) begin
          e = infl.pop_front();
          if (!e.doomed) efifo.push_back('{pc: e.addr, instr: e.addr + 32'h13});
        end
        if (exp_rv && imem.imem_req_ready) begin
          infl.push_back('{addr: m_pc, doomed: 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      m_started = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] idr_pat;
    logic [39:0] rdy_pat;
    idr_pat = 40'hF3_5A_E7_96_BD;
    rdy_pat = 40'hDB_7E_6D_F7_AF;

    rst_n               = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = 32'h0;
    id_ready            = 1'b1;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;

    // Reset values and start-up stream.
    tick(); tick();
    chk("lit_rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
    chk("lit_rst_id_instr", id_instr, 32'h0000_0013);
    rst_n = 1'b1;
    tick();
    chk("lit_c1_req_valid", 32'(imem.imem_req_valid), 32'd1);
    chk("lit_c1_req_addr", imem.imem_req_addr, 32'h0);
    tick();
    chk("lit_c2_req_addr", imem.imem_req_addr, 32'h4);
    tick();
    chk("lit_c3_id_pc", id_pc, 32'h0);
    chk("lit_c3_id_instr", id_instr, 32'h13);
    chk("lit_c3_op_code", 32'(id_op_code), 32'h13);
    chk("lit_c3_req_valid", 32'(imem.imem_req_valid), 32'd0);
    tick();
    chk("lit_c4_id_pc", id_pc, 32'h4);
    chk("lit_c4_id_instr", id_instr, 32'h17);
    chk("lit_c4_req_addr", imem.imem_req_addr, 32'h8);

    // Back-pressure: FIFO fills, issue stops, head holds.
    id_ready = 1'b0;
    tick(); tick(); tick();
    chk("lit_stall_req_valid", 32'(imem.imem_req_valid), 32'd0);
    chk("lit_stall_id_pc", id_pc, 32'h4);
    chk("lit_stall_id_instr", id_instr, 32'h17);
    id_ready = 1'b1;
    tick();
    chk("lit_drain_id_pc8", id_pc, 32'h8);
    chk("lit_drain_req_addr", imem.imem_req_addr, 32'hC);
    tick();
    chk("lit_drain_empty", 32'(id_valid), 32'd0);
    tick();
    chk("lit_drain_id_pc12", id_pc, 32'hC);

    // Redirect with two requests in flight on a slow memory.
    lat = 3;
    for (int i = 0; i < 30 && memq.size() < 2; i++) tick();
    chk("lit_two_in_flight", 32'(memq.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    chk("lit_redir_no_req", 32'(imem.imem_req_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    for (int i = 0; i < 30 && !id_valid; i++) tick();
    chk("lit_redir_id_valid", 32'(id_valid), 32'd1);
    chk("lit_redir_id_pc", id_pc, 32'h100);
    chk("lit_redir_id_instr", id_instr, 32'h113);
    lat = 1;

    // Redirect coinciding with a response and a pop.
    for (int i = 0; i < 30 && !(imem.imem_rsp_valid && id_valid); i++) tick();
    chk("lit_rsp_pop_cycle", 32'(imem.imem_rsp_valid && id_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("lit_flush_id_valid", 32'(id_valid), 32'd0);
    chk("lit_flush_id_instr", id_instr, 32'h0000_0013);
    chk("lit_flush_req_valid", 32'(imem.imem_req_valid), 32'd1);
    chk("lit_flush_req_addr", imem.imem_req_addr, 32'h200);

    // Misaligned target near the top of the address space wraps to zero.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    #1;
    chk("lit_wrap_addr_hi", imem.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("lit_wrap_addr_0", imem.imem_req_addr, 32'h0);
    for (int i = 0; i < 30 && !id_valid; i++) tick();
    chk("lit_wrap_id_pc_hi", id_pc, 32'hFFFF_FFFC);
    chk("lit_wrap_id_instr", id_instr, 32'h0000_000F);
    tick();
    chk("lit_wrap_id_pc_0", id_pc, 32'h0);
    chk("lit_wrap_id_instr0", id_instr, 32'h13);

    // Asynchronous reset with a full FIFO.
    id_ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk("lit_full_id_valid", 32'(id_valid), 32'd1);
    chk("lit_full_req_valid", 32'(imem.imem_req_valid), 32'd0);
    #1;
    rst_n               = 1'b0;
    imem.imem_rsp_valid = 1'b0;
    memq.delete();
    #1;
    chk("lit_async_id_valid", 32'(id_valid), 32'd0);
    chk("lit_async_req_valid", 32'(imem.imem_req_valid), 32'd0);
    chk("lit_async_id_instr", id_instr, 32'h0000_0013);
    chk("lit_async_id_pc", id_pc, 32'h0);
    tick(); tick();
    rst_n    = 1'b1;
    id_ready = 1'b1;
    tick();
    chk("lit_rerun_req_valid", 32'(imem.imem_req_valid), 32'd1);
    chk("lit_rerun_req_addr", imem.imem_req_addr, 32'h0);

    // Mixed back-pressure on both sides with one redirect.
    for (int i = 0; i < 40; i++) begin
      id_ready            = idr_pat[i];
      imem.imem_req_ready = rdy_pat[i];
      redirect_valid      = (i == 20);
      redirect_pc         = 32'h40;
      tick();
    end
    redirect_valid      = 1'b0;
    imem.imem_req_ready = 1'b1;
    id_ready            = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
